// File: rtl/spi_rx_byte_capture.sv
// SPI slave receiver: synchronizes SCLK/MOSI/SS_n into clk, deserializes MOSI
// into DATA_WIDTH-bit words and holds the last complete word on data_out.
// Optional MISO echo of the previous word: define SPI_RX_MISO_ECHO_EN.
// SYNC_STAGES legal range is 2..3; DATA_WIDTH must be at least 2.
module spi_rx_byte_capture #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MSB_FIRST   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  input  logic                  spi_ss_n,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  frame_active,
  output logic [7:0]            byte_count,
  output logic                  short_frame
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned BC_W  = 8;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic             SCLK_IDLE = 1'(CPOL);
  localparam logic             SAMPLE_ON_RISE = (CPOL == CPHA);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ss_prev_q, ss_prev_d;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic [BC_W-1:0]        byte_count_q, byte_count_d;
  logic                   short_frame_q, short_frame_d;

  logic                   sclk_s, mosi_s, ss_s;
  logic                   sclk_rise, sclk_fall, sample_edge;
  logic                   ss_fall, ss_rise;
  logic [DATA_WIDTH-1:0]  word_c;

  // Synchronizer chains and edge-history next values
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;
  end

  // Synchronizer and history flops; ss_n resets as "selected" so a frame
  // always needs a fresh ss_n fall after reset, SCLK resets to its idle level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
      mosi_sync_q <= '0;
      ss_sync_q   <= '0;
      sclk_prev_q <= SCLK_IDLE;
      ss_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_sync_q   <= ss_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign sample_edge = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
  assign ss_fall     = ~ss_s & ss_prev_q;
  assign ss_rise     = ss_s & ~ss_prev_q;

  // Word as it would look with the current synchronized MOSI bit shifted in
  assign word_c = (MSB_FIRST != 0) ? {shift_q[DATA_WIDTH-2:0], mosi_s}
                                   : {mosi_s, shift_q[DATA_WIDTH-1:1]};

  // Frame FSM next-state and datapath; word completion wins over ss_n rise
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    byte_count_d  = byte_count_q;
    short_frame_d = short_frame_q;

    unique case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (ss_fall) begin
          state_d       = S_ACTIVE;
          byte_count_d  = '0;
          short_frame_d = 1'b0;
          shift_d       = '0;
        end
      end
      S_ACTIVE: begin
        if (sample_edge) begin
          shift_d = word_c;
          if (bit_cnt_q == LAST_BIT) begin
            data_out_d   = word_c;
            data_valid_d = 1'b1;
            bit_cnt_d    = '0;
            if (byte_count_q != {BC_W{1'b1}}) begin
              byte_count_d = byte_count_q + BC_W'(1);
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        if (ss_rise) begin
          state_d = S_IDLE;
          if (bit_cnt_d != '0) begin
            short_frame_d = 1'b1;
          end
          bit_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame FSM state and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      byte_count_q  <= '0;
      short_frame_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      byte_count_q  <= byte_count_d;
      short_frame_q <= short_frame_d;
    end
  end

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign byte_count   = byte_count_q;
  assign short_frame  = short_frame_q;
  assign frame_active = (state_q == S_ACTIVE);

`ifdef SPI_RX_MISO_ECHO_EN
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic                  shift_edge;

  assign shift_edge = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;

  // Echo shifter: reload the last completed word at each word boundary
  always_comb begin
    tx_d = tx_q;
    if (state_q == S_IDLE) begin
      if (ss_fall) begin
        tx_d = data_out_q;
      end
    end else if (shift_edge) begin
      if (bit_cnt_q == '0) begin
        tx_d = data_out_q;
      end else begin
        tx_d = (MSB_FIRST != 0) ? {tx_q[DATA_WIDTH-2:0], 1'b0}
                                : {1'b0, tx_q[DATA_WIDTH-1:1]};
      end
    end
  end

  // Echo shifter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_q <= '0;
    end else begin
      tx_q <= tx_d;
    end
  end

  assign spi_miso    = (MSB_FIRST != 0) ? tx_q[DATA_WIDTH-1] : tx_q[0];
  assign spi_miso_oe = frame_active;
`else
  assign spi_miso    = 1'b0;
  assign spi_miso_oe = 1'b0;
`endif

endmodule

// File: doc/spi_rx_byte_capture.md
Name: spi_rx_byte_capture

Overview:
- SPI slave receiver, one clock domain.
- Synchronizes the external SCLK/MOSI/SS_n pins into the system clock domain and deserializes MOSI into bytes.
- Presents the last complete byte as a stable parallel word. data_out connects directly to the in_port of the downstream input PIO, which the Nios reads over Avalon.
- Also provides a one-cycle byte strobe, a per-frame byte count and a short-frame flag for debug/status PIOs.

Parameters:
- DATA_WIDTH, 8, bits per SPI word; also the width of data_out.
- CPOL, 0, SCLK idle level.
- CPHA, 0, sample on leading (0) or trailing (1) SCLK edge.
- SYNC_STAGES, 2, flops in each pin synchronizer; legal range 2..3.
- MSB_FIRST, 1, 1 = first received bit lands in data_out[DATA_WIDTH-1].

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- spi_sclk  in  1  SPI clock from the external master.
- spi_mosi  in  1  master-out data.
- spi_ss_n  in  1  slave select, active low.
- spi_miso  out  1  slave-out data (see Optional Feature).
- spi_miso_oe  out  1  MISO output enable.
- data_out  out  DATA_WIDTH  last completed word; feeds the PIO in_port.
- data_valid  out  1  one-clk pulse when data_out updates.
- frame_active  out  1  synchronized, inverted ss_n.
- byte_count  out  8  words completed in the current/last frame, saturating.
- short_frame  out  1  sticky: last frame ended mid-word.

Behaviour:
- Reset: all outputs are 0 and all internal state is cleared. The SCLK edge-detect history register resets to CPOL so no false edge is seen on release.
- Sync: each pin passes through a SYNC_STAGES-flop synchronizer. One further register holds the previous synchronized SCLK. An edge is detected when the synchronized SCLK differs from that register.
- Sample edge: rising when CPOL==CPHA, falling otherwise. Shift edge is the opposite edge.
- Requirement: f_clk >= 4 x f_sclk. No behaviour is guaranteed below this.
- FSM:
  - IDLE: synchronized ss_n = 1. bit_cnt held at 0.
  - IDLE -> ACTIVE on synchronized ss_n falling: clear byte_count, clear short_frame, clear bit_cnt.
  - ACTIVE: on each sample edge, shift the synchronized MOSI into shift_reg (direction per MSB_FIRST) and increment bit_cnt.
  - When bit_cnt == DATA_WIDTH-1 at a sample edge:
    - data_out <= the complete word, including the current bit.
    - data_valid pulses for exactly 1 clk.
    - bit_cnt <= 0.
    - byte_count increments, saturating at 255.
  - ACTIVE -> IDLE on synchronized ss_n rising. If bit_cnt != 0, set short_frame and discard the partial word; data_out is unchanged.
- Latency: data_out and data_valid update on the (SYNC_STAGES+1)th clk rising edge after the final sample edge reaches the spi_sclk pin.
- data_out holds its value indefinitely between words and across frames. It changes only on word completion or reset.
- Simultaneous final sample edge and ss_n rise in the same clk: the word completes first (data_out and data_valid update, short_frame stays 0), then the FSM enters IDLE.
- SCLK edges while IDLE are ignored.
- Reset mid-word: the partial word is lost and there is no data_valid pulse. After reset release, the FSM starts in IDLE even if ss_n is low, and requires a fresh ss_n falling edge.
- frame_active equals the FSM state (ACTIVE = 1).

Optional Feature:
- Macro: SPI_RX_MISO_ECHO_EN.
- Defined:
  - spi_miso_oe = frame_active.
  - spi_miso shifts out the previously completed data_out, in the same bit order as receive, updating on each shift edge.
  - With CPHA=0, the first bit is driven on frame start.
  - The master therefore reads word N-1 while sending word N. The first word of the frame after reset echoes 0x00.
- Undefined: spi_miso = 0 and spi_miso_oe = 0, constant. The ports remain present.

Test Plan:
- Mode 0, SCLK = clk/8, ss_n low, send 0xA5, ss_n high -> data_out = 0xA5 exactly SYNC_STAGES+1 clks after the 8th rising edge; one data_valid pulse; byte_count = 1; short_frame = 0.
- One frame carrying 0x01, 0x80, 0xFF -> three data_valid pulses, data_out ends at 0xFF, byte_count = 3; the next ss_n fall clears byte_count to 0.
- Send 0x3C, then a frame of 5 bits only -> no data_valid for the partial frame, data_out stays 0x3C, short_frame = 1; the next full frame clears it.
- Assert reset_n low after 4 bits of 0x5A -> all outputs 0 immediately. Release while ss_n is still low -> no word captured until ss_n toggles high then low.
- CPOL=1, CPHA=1, send 0xC3 -> data_out = 0xC3 sampled on SCLK rising edges. MSB_FIRST=0 with 0xC3 on the wire -> data_out = 0xC3 with the first received bit in bit 0.
- SPI_RX_MISO_ECHO_EN defined, frame sends 0x12 then 0x34 -> MISO carries 0x00 during word 1 and 0x12 during word 2; spi_miso_oe is high only while ss_n is low.
